// File: rtl/id_stage_pipe_if.sv
// id_stage_pipe_if
//   Bundles every bus signal that the ID stage exchanges with its neighbours:
//   the IF/ID valid/ready handshake, the write-back port, the flush input from
//   EX, and the ID/EX pipeline register contents with their ready.
//   master : the surroundings (IF, WB, EX) that drive the stage
//   slave  : the ID stage itself
interface id_stage_pipe_if #(
   parameter int XLEN              = 32,
   parameter int NUM_REG           = 32,
   parameter int REG_ADDR_WIDTH    = $clog2(NUM_REG),
   parameter int ALU_CONTROL_WIDTH = 4,
   parameter int RESULTSRC_WIDTH   = 2
);
   logic                         id_valid;
   logic [31:0]                  id_instr;
   logic [XLEN-1:0]              id_pc;
   logic                         id_ready;

   logic                         wb_we;
   logic [REG_ADDR_WIDTH-1:0]    wb_rd;
   logic [XLEN-1:0]              wb_data;

   logic                         flush;
   logic                         ex_ready;

   logic                         ex_valid;
   logic [XLEN-1:0]              ex_pc;
   logic [XLEN-1:0]              ex_rs1_data;
   logic [XLEN-1:0]              ex_rs2_data;
   logic [REG_ADDR_WIDTH-1:0]    ex_rs1;
   logic [REG_ADDR_WIDTH-1:0]    ex_rs2;
   logic [REG_ADDR_WIDTH-1:0]    ex_rd;
   logic [XLEN-1:0]              ex_imm;
   logic                         ex_alu_src;
   logic                         ex_mem_write;
   logic                         ex_reg_write;
   logic                         ex_branch;
   logic                         ex_jump;
   logic [RESULTSRC_WIDTH-1:0]   ex_result_src;
   logic [ALU_CONTROL_WIDTH-1:0] ex_alu_control;
   logic                         ex_illegal;

   modport master (
      output id_valid, id_instr, id_pc,
      input  id_ready,
      output wb_we, wb_rd, wb_data,
      output flush, ex_ready,
      input  ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_rs1, ex_rs2, ex_rd,
      input  ex_imm, ex_alu_src, ex_mem_write, ex_reg_write, ex_branch, ex_jump,
      input  ex_result_src, ex_alu_control, ex_illegal
   );

   modport slave (
      input  id_valid, id_instr, id_pc,
      output id_ready,
      input  wb_we, wb_rd, wb_data,
      input  flush, ex_ready,
      output ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_rs1, ex_rs2, ex_rd,
      output ex_imm, ex_alu_src, ex_mem_write, ex_reg_write, ex_branch, ex_jump,
      output ex_result_src, ex_alu_control, ex_illegal
   );
endinterface

// File: rtl/id_stage_pipe.sv
// id_stage_pipe
//   Pipelined RV32I decode stage. Takes an instruction/PC from IF over a
//   valid/ready handshake, decodes it, reads the register file (with
//   same-cycle write-back bypass), detects load-use hazards and registers the
//   result into the ID/EX pipeline register with hold, bubble and flush.
// Ports
//   clk    : rising-edge clock
//   rst    : synchronous, active-high reset
//   id_bus : id_stage_pipe_if.slave (IF handshake, write-back, flush, ID/EX)
module id_stage_pipe #(
   parameter int XLEN              = 32,
   parameter int NUM_REG           = 32,
   parameter int REG_ADDR_WIDTH    = $clog2(NUM_REG),
   parameter int ALU_CONTROL_WIDTH = 4,
   parameter int RESULTSRC_WIDTH   = 2
) (
   input logic           clk,
   input logic           rst,
   id_stage_pipe_if.slave id_bus
);
   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;

   localparam logic [ALU_CONTROL_WIDTH-1:0] ALU_ADD = ALU_CONTROL_WIDTH'(0);
   localparam logic [ALU_CONTROL_WIDTH-1:0] ALU_SUB = ALU_CONTROL_WIDTH'(1);
   localparam logic [ALU_CONTROL_WIDTH-1:0] ALU_AND = ALU_CONTROL_WIDTH'(2);
   localparam logic [ALU_CONTROL_WIDTH-1:0] ALU_OR  = ALU_CONTROL_WIDTH'(3);
   localparam logic [ALU_CONTROL_WIDTH-1:0] ALU_XOR = ALU_CONTROL_WIDTH'(4);
   localparam logic [ALU_CONTROL_WIDTH-1:0] ALU_SLT = ALU_CONTROL_WIDTH'(5);
   localparam logic [ALU_CONTROL_WIDTH-1:0] ALU_SLL = ALU_CONTROL_WIDTH'(6);
   localparam logic [ALU_CONTROL_WIDTH-1:0] ALU_SRL = ALU_CONTROL_WIDTH'(7);
   localparam logic [ALU_CONTROL_WIDTH-1:0] ALU_SRA = ALU_CONTROL_WIDTH'(8);

   localparam logic [RESULTSRC_WIDTH-1:0] RES_ALU = RESULTSRC_WIDTH'(0);
   localparam logic [RESULTSRC_WIDTH-1:0] RES_MEM = RESULTSRC_WIDTH'(1);
   localparam logic [RESULTSRC_WIDTH-1:0] RES_PC4 = RESULTSRC_WIDTH'(2);

   // instruction fields
   logic [31:0]               w_instr;
   logic [6:0]                w_opcode;
   logic [2:0]                w_funct3;
   logic [6:0]                w_funct7;
   logic [REG_ADDR_WIDTH-1:0] w_rs1;
   logic [REG_ADDR_WIDTH-1:0] w_rs2;
   logic [REG_ADDR_WIDTH-1:0] w_rd;

   assign w_instr  = id_bus.id_instr;
   assign w_opcode = w_instr[6:0];
   assign w_funct3 = w_instr[14:12];
   assign w_funct7 = w_instr[31:25];
   assign w_rs1    = w_instr[15 +: REG_ADDR_WIDTH];
   assign w_rs2    = w_instr[20 +: REG_ADDR_WIDTH];
   assign w_rd     = w_instr[7 +: REG_ADDR_WIDTH];

   // immediates, all sign-extended from instr[31]
   logic [XLEN-1:0] w_imm_i, w_imm_s, w_imm_b, w_imm_j, w_imm_u;

   assign w_imm_i = {{(XLEN-12){w_instr[31]}}, w_instr[31:20]};
   assign w_imm_s = {{(XLEN-12){w_instr[31]}}, w_instr[31:25], w_instr[11:7]};
   assign w_imm_b = {{(XLEN-12){w_instr[31]}}, w_instr[7], w_instr[30:25],
                     w_instr[11:8], 1'b0};
   assign w_imm_j = {{(XLEN-20){w_instr[31]}}, w_instr[19:12], w_instr[20],
                     w_instr[30:21], 1'b0};
   assign w_imm_u = {{(XLEN-31){w_instr[31]}}, w_instr[30:12], 12'b0};

   // decode
   logic                         w_illegal;
   logic                         w_reg_write;
   logic                         w_mem_write;
   logic                         w_alu_src;
   logic                         w_branch;
   logic                         w_jump;
   logic [RESULTSRC_WIDTH-1:0]   w_result_src;
   logic [ALU_CONTROL_WIDTH-1:0] w_alu_control;
   logic [XLEN-1:0]              w_imm;
   logic                         w_uses_rs1;
   logic                         w_uses_rs2;

   always_comb begin
      w_illegal     = 1'b0;
      w_reg_write   = 1'b0;
      w_mem_write   = 1'b0;
      w_alu_src     = 1'b0;
      w_branch      = 1'b0;
      w_jump        = 1'b0;
      w_result_src  = RES_ALU;
      w_alu_control = ALU_ADD;
      w_imm         = '0;
      w_uses_rs1    = 1'b1;
      w_uses_rs2    = 1'b0;
      case (w_opcode)
         OP_R: begin
            w_reg_write = 1'b1;
            w_uses_rs2  = 1'b1;
            case (w_funct3)
               3'b000:  w_alu_control = w_funct7[5] ? ALU_SUB : ALU_ADD;
               3'b001:  w_alu_control = ALU_SLL;
               3'b010:  w_alu_control = ALU_SLT;
               3'b100:  w_alu_control = ALU_XOR;
               3'b101:  w_alu_control = w_funct7[5] ? ALU_SRA : ALU_SRL;
               3'b110:  w_alu_control = ALU_OR;
               3'b111:  w_alu_control = ALU_AND;
               default: w_illegal = 1'b1;
            endcase
            // only 0x00 and 0x20 exist, and 0x20 only for SUB/SRA
            if (w_funct7 != 7'h00 && w_funct7 != 7'h20)
               w_illegal = 1'b1;
            if (w_funct7[5] && w_funct3 != 3'b000 && w_funct3 != 3'b101)
               w_illegal = 1'b1;
         end
         OP_I: begin
            w_reg_write = 1'b1;
            w_alu_src   = 1'b1;
            w_imm       = w_imm_i;
            // funct7 bits are immediate bits here except for shifts
            case (w_funct3)
               3'b000:  w_alu_control = ALU_ADD;
               3'b010:  w_alu_control = ALU_SLT;
               3'b100:  w_alu_control = ALU_XOR;
               3'b110:  w_alu_control = ALU_OR;
               3'b111:  w_alu_control = ALU_AND;
               3'b001: begin
                  w_alu_control = ALU_SLL;
                  if (w_funct7 != 7'h00)
                     w_illegal = 1'b1;
               end
               3'b101: begin
                  w_alu_control = w_funct7[5] ? ALU_SRA : ALU_SRL;
                  if ((w_funct7 & 7'h5F) != 7'h00)
                     w_illegal = 1'b1;
               end
               default: w_illegal = 1'b1;
            endcase
         end
         OP_LOAD: begin
            w_reg_write  = 1'b1;
            w_alu_src    = 1'b1;
            w_result_src = RES_MEM;
            w_imm        = w_imm_i;
            if (w_funct3 == 3'b011 || w_funct3 == 3'b110 || w_funct3 == 3'b111)
               w_illegal = 1'b1;
         end
         OP_STORE: begin
            w_mem_write = 1'b1;
            w_alu_src   = 1'b1;
            w_uses_rs2  = 1'b1;
            w_imm       = w_imm_s;
            if (w_funct3 > 3'b010)
               w_illegal = 1'b1;
         end
         OP_BRANCH: begin
            w_branch      = 1'b1;
            w_uses_rs2    = 1'b1;
            w_alu_control = ALU_SUB;
            w_imm         = w_imm_b;
            if (w_funct3 != 3'b000 && w_funct3 != 3'b001)
               w_illegal = 1'b1;
         end
         OP_JAL: begin
            w_reg_write  = 1'b1;
            w_jump       = 1'b1;
            w_result_src = RES_PC4;
            w_imm        = w_imm_j;
            w_uses_rs1   = 1'b0;
         end
         OP_LUI: begin
            w_reg_write = 1'b1;
            w_alu_src   = 1'b1;
            w_imm       = w_imm_u;
            w_uses_rs1  = 1'b0;
         end
         default: w_illegal = 1'b1;
      endcase
      // an illegal instruction must not change architectural state
      if (w_illegal) begin
         w_reg_write = 1'b0;
         w_mem_write = 1'b0;
         w_branch    = 1'b0;
         w_jump      = 1'b0;
      end
   end

   // register file
   logic [XLEN-1:0] r_regs [NUM_REG];
   logic            w_wb_en;
   logic [XLEN-1:0] w_rs1_data;
   logic [XLEN-1:0] w_rs2_data;

   assign w_wb_en = id_bus.wb_we && (id_bus.wb_rd != '0);

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_REG; i++)
            r_regs[i] <= '0;
      end else if (w_wb_en) begin
         r_regs[id_bus.wb_rd] <= id_bus.wb_data;
      end
   end

   always_comb begin
      w_rs1_data = r_regs[w_rs1];
      w_rs2_data = r_regs[w_rs2];
      if (w_wb_en && id_bus.wb_rd == w_rs1)
         w_rs1_data = id_bus.wb_data;
      if (w_wb_en && id_bus.wb_rd == w_rs2)
         w_rs2_data = id_bus.wb_data;
      if (w_rs1 == '0)
         w_rs1_data = '0;
      if (w_rs2 == '0)
         w_rs2_data = '0;
   end

   // ID/EX pipeline register
   logic                         r_ex_valid;
   logic [XLEN-1:0]              r_ex_pc;
   logic [XLEN-1:0]              r_ex_rs1_data;
   logic [XLEN-1:0]              r_ex_rs2_data;
   logic [REG_ADDR_WIDTH-1:0]    r_ex_rs1;
   logic [REG_ADDR_WIDTH-1:0]    r_ex_rs2;
   logic [REG_ADDR_WIDTH-1:0]    r_ex_rd;
   logic [XLEN-1:0]              r_ex_imm;
   logic                         r_ex_alu_src;
   logic                         r_ex_mem_write;
   logic                         r_ex_reg_write;
   logic                         r_ex_branch;
   logic                         r_ex_jump;
   logic [RESULTSRC_WIDTH-1:0]   r_ex_result_src;
   logic [ALU_CONTROL_WIDTH-1:0] r_ex_alu_control;
   logic                         r_ex_illegal;

   logic w_advance;
   logic w_hz;

   assign w_advance = !r_ex_valid || id_bus.ex_ready;

   // a load in EX has no data until MEM, so a dependent instruction waits
   // exactly one cycle (the load moves on while a bubble enters EX)
   assign w_hz = r_ex_valid && (r_ex_result_src == RES_MEM) && (r_ex_rd != '0) &&
                 ((r_ex_rd == w_rs1 && w_uses_rs1) || (r_ex_rd == w_rs2 && w_uses_rs2));

   assign id_bus.id_ready = !rst && (id_bus.flush || (w_advance && !w_hz));

   always_ff @(posedge clk) begin
      if (rst) begin
         r_ex_valid       <= 1'b0;
         r_ex_pc          <= '0;
         r_ex_rs1_data    <= '0;
         r_ex_rs2_data    <= '0;
         r_ex_rs1         <= '0;
         r_ex_rs2         <= '0;
         r_ex_rd          <= '0;
         r_ex_imm         <= '0;
         r_ex_alu_src     <= 1'b0;
         r_ex_mem_write   <= 1'b0;
         r_ex_reg_write   <= 1'b0;
         r_ex_branch      <= 1'b0;
         r_ex_jump        <= 1'b0;
         r_ex_result_src  <= '0;
         r_ex_alu_control <= '0;
         r_ex_illegal     <= 1'b0;
      end else if (id_bus.flush) begin
         r_ex_valid     <= 1'b0;
         r_ex_reg_write <= 1'b0;
         r_ex_mem_write <= 1'b0;
         r_ex_branch    <= 1'b0;
         r_ex_jump      <= 1'b0;
      end else if (!w_advance) begin
         // hold: operands captured earlier stay as they were
      end else if (w_hz) begin
         r_ex_valid     <= 1'b0;
         r_ex_reg_write <= 1'b0;
         r_ex_mem_write <= 1'b0;
         r_ex_branch    <= 1'b0;
         r_ex_jump      <= 1'b0;
      end else begin
         r_ex_valid       <= id_bus.id_valid;
         r_ex_pc          <= id_bus.id_pc;
         r_ex_rs1_data    <= w_rs1_data;
         r_ex_rs2_data    <= w_rs2_data;
         r_ex_rs1         <= w_rs1;
         r_ex_rs2         <= w_rs2;
         r_ex_rd          <= w_rd;
         r_ex_imm         <= w_imm;
         r_ex_alu_src     <= w_alu_src;
         r_ex_mem_write   <= id_bus.id_valid && w_mem_write;
         r_ex_reg_write   <= id_bus.id_valid && w_reg_write;
         r_ex_branch      <= id_bus.id_valid && w_branch;
         r_ex_jump        <= id_bus.id_valid && w_jump;
         r_ex_result_src  <= w_result_src;
         r_ex_alu_control <= w_alu_control;
         r_ex_illegal     <= w_illegal;
      end
   end

   assign id_bus.ex_valid       = r_ex_valid;
   assign id_bus.ex_pc          = r_ex_pc;
   assign id_bus.ex_rs1_data    = r_ex_rs1_data;
   assign id_bus.ex_rs2_data    = r_ex_rs2_data;
   assign id_bus.ex_rs1         = r_ex_rs1;
   assign id_bus.ex_rs2         = r_ex_rs2;
   assign id_bus.ex_rd          = r_ex_rd;
   assign id_bus.ex_imm         = r_ex_imm;
   assign id_bus.ex_alu_src     = r_ex_alu_src;
   assign id_bus.ex_mem_write   = r_ex_mem_write;
   assign id_bus.ex_reg_write   = r_ex_reg_write;
   assign id_bus.ex_branch      = r_ex_branch;
   assign id_bus.ex_jump        = r_ex_jump;
   assign id_bus.ex_result_src  = r_ex_result_src;
   assign id_bus.ex_alu_control = r_ex_alu_control;
   assign id_bus.ex_illegal     = r_ex_illegal;

endmodule

// File: tb/tb_id_stage_pipe.sv
// tb_id_stage_pipe
//   Directed-vector bench for id_stage_pipe; expected values are hand-computed
//   from the RV32I encodings listed beside each vector.
module tb_id_stage_pipe;
   logic clk;
   logic rst;
   int   n_chk;
   int   n_err;

   id_stage_pipe_if bus ();

   id_stage_pipe dut (
      .clk    (clk),
      .rst    (rst),
      .id_bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] instr;
      logic [31:0] imm;
      logic [3:0]  alu;
      logic [1:0]  res;
      logic        rw;
      logic        mw;
      logic        br;
      logic        jmp;
      logic        ill;
   } vec_t;

   vec_t vecs [7];

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic present(input logic [31:0] instr, input logic [31:0] pc);
      bus.id_valid = 1'b1;
      bus.id_instr = instr;
      bus.id_pc    = pc;
   endtask

   initial begin
      n_chk = 0;
      n_err = 0;
      // beq x1,x2,-4
      vecs[0] = '{32'hFE208EE3, 32'hFFFFFFFC, 4'd1, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      // srai x1,x2,3
      vecs[1] = '{32'h40315093, 32'h00000403, 4'd8, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      // addi x1,x0,0x400 (bit 30 set, still ADD)
      vecs[2] = '{32'h40000093, 32'h00000400, 4'd0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      // sw x2,12(x1)
      vecs[3] = '{32'h0020A623, 32'h0000000C, 4'd0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      // lui x7,0x12345
      vecs[4] = '{32'h123453B7, 32'h12345000, 4'd0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      // jal x1,16
      vecs[5] = '{32'h010000EF, 32'h00000010, 4'd0, 2'd2, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
      // opcode 0x7F
      vecs[6] = '{32'h0000007F, 32'h00000000, 4'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

      rst          = 1'b1;
      bus.id_valid = 1'b1;
      bus.id_instr = 32'h003100B3;
      bus.id_pc    = 32'h0;
      bus.wb_we    = 1'b0;
      bus.wb_rd    = '0;
      bus.wb_data  = '0;
      bus.flush    = 1'b0;
      bus.ex_ready = 1'b1;

      // reset
      #1;
      check_eq("rst_id_ready", 32'(bus.id_ready), 0);
      tick();
      tick();
      check_eq("rst_ex_valid", 32'(bus.ex_valid), 0);
      check_eq("rst_reg_write", 32'(bus.ex_reg_write), 0);
      check_eq("rst_pc", bus.ex_pc, 0);
      check_eq("rst_imm", bus.ex_imm, 0);
      rst          = 1'b0;
      bus.id_valid = 1'b0;

      // x2=5, x3=7 then add x1,x2,x3
      bus.wb_we = 1'b1; bus.wb_rd = 5'd2; bus.wb_data = 32'd5;
      tick();
      bus.wb_rd = 5'd3; bus.wb_data = 32'd7;
      tick();
      bus.wb_we = 1'b0;
      present(32'h003100B3, 32'h100);
      #1;
      check_eq("add_id_ready", 32'(bus.id_ready), 1);
      tick();
      check_eq("add_valid", 32'(bus.ex_valid), 1);
      check_eq("add_rs1_data", bus.ex_rs1_data, 5);
      check_eq("add_rs2_data", bus.ex_rs2_data, 7);
      check_eq("add_rd", 32'(bus.ex_rd), 1);
      check_eq("add_alu", 32'(bus.ex_alu_control), 0);
      check_eq("add_rw", 32'(bus.ex_reg_write), 1);
      check_eq("add_pc", bus.ex_pc, 32'h100);

      // same-cycle bypass of x2
      bus.wb_we = 1'b1; bus.wb_rd = 5'd2; bus.wb_data = 32'hAA;
      present(32'h003100B3, 32'h104);
      tick();
      check_eq("byp_rs1_data", bus.ex_rs1_data, 32'hAA);
      check_eq("byp_rs2_data", bus.ex_rs2_data, 7);
      // write to x0 is ignored, add x1,x0,x0
      bus.wb_rd = 5'd0; bus.wb_data = 32'h55;
      present(32'h000000B3, 32'h108);
      tick();
      check_eq("x0_byp_rs1", bus.ex_rs1_data, 0);
      check_eq("x0_byp_rs2", bus.ex_rs2_data, 0);
      // add x1,x0,x2: x0 still zero, x2 now holds 0xAA
      bus.wb_we = 1'b0;
      present(32'h002000B3, 32'h10C);
      tick();
      check_eq("x0_rd_rs1", bus.ex_rs1_data, 0);
      check_eq("x2_rd_rs2", bus.ex_rs2_data, 32'hAA);

      // load-use: lw x5,8(x1); add x6,x5,x4
      present(32'h0080A283, 32'h110);
      tick();
      check_eq("lw_valid", 32'(bus.ex_valid), 1);
      check_eq("lw_res", 32'(bus.ex_result_src), 1);
      check_eq("lw_rd", 32'(bus.ex_rd), 5);
      check_eq("lw_imm", bus.ex_imm, 8);
      check_eq("lw_alu_src", 32'(bus.ex_alu_src), 1);
      present(32'h00428333, 32'h114);
      #1;
      check_eq("hz_id_ready", 32'(bus.id_ready), 0);
      tick();
      check_eq("bubble_valid", 32'(bus.ex_valid), 0);
      check_eq("bubble_rw", 32'(bus.ex_reg_write), 0);
      #1;
      check_eq("post_hz_ready", 32'(bus.id_ready), 1);
      tick();
      check_eq("use_valid", 32'(bus.ex_valid), 1);
      check_eq("use_rs1", 32'(bus.ex_rs1), 5);
      check_eq("use_rs2", 32'(bus.ex_rs2), 4);
      check_eq("use_rd", 32'(bus.ex_rd), 6);
      check_eq("use_pc", bus.ex_pc, 32'h114);

      // EX back-pressure for 3 cycles, addi x1,x0,-1 waits in ID
      bus.ex_ready = 1'b0;
      present(32'hFFF00093, 32'h118);
      for (int i = 0; i < 3; i++) begin
         #1;
         check_eq($sformatf("stall%0d_ready", i), 32'(bus.id_ready), 0);
         tick();
         check_eq($sformatf("stall%0d_valid", i), 32'(bus.ex_valid), 1);
         check_eq($sformatf("stall%0d_rd", i), 32'(bus.ex_rd), 6);
         check_eq($sformatf("stall%0d_pc", i), bus.ex_pc, 32'h114);
      end
      bus.ex_ready = 1'b1;
      #1;
      check_eq("release_ready", 32'(bus.id_ready), 1);
      tick();
      check_eq("addi_imm", bus.ex_imm, 32'hFFFFFFFF);
      check_eq("addi_alu", 32'(bus.ex_alu_control), 0);
      check_eq("addi_rd", 32'(bus.ex_rd), 1);
      check_eq("addi_pc", bus.ex_pc, 32'h118);
      check_eq("addi_rw", 32'(bus.ex_reg_write), 1);

      // decode vectors
      for (int k = 0; k < 7; k++) begin
         present(vecs[k].instr, 32'h200 + 32'(4 * k));
         tick();
         check_eq($sformatf("v%0d_valid", k), 32'(bus.ex_valid), 1);
         check_eq($sformatf("v%0d_imm", k), bus.ex_imm, vecs[k].imm);
         check_eq($sformatf("v%0d_alu", k), 32'(bus.ex_alu_control), 32'(vecs[k].alu));
         check_eq($sformatf("v%0d_res", k), 32'(bus.ex_result_src), 32'(vecs[k].res));
         check_eq($sformatf("v%0d_rw", k), 32'(bus.ex_reg_write), 32'(vecs[k].rw));
         check_eq($sformatf("v%0d_mw", k), 32'(bus.ex_mem_write), 32'(vecs[k].mw));
         check_eq($sformatf("v%0d_br", k), 32'(bus.ex_branch), 32'(vecs[k].br));
         check_eq($sformatf("v%0d_jmp", k), 32'(bus.ex_jump), 32'(vecs[k].jmp));
         check_eq($sformatf("v%0d_ill", k), 32'(bus.ex_illegal), 32'(vecs[k].ill));
      end

      // invalid slot with a store word on the bus loads as a dead entry
      present(32'h0020A623, 32'h300);
      bus.id_valid = 1'b0;
      tick();
      check_eq("novalid_valid", 32'(bus.ex_valid), 0);
      check_eq("novalid_mw", 32'(bus.ex_mem_write), 0);

      // flush during a load-use stall
      present(32'h0080A283, 32'h400);
      tick();
      check_eq("fl_lw_valid", 32'(bus.ex_valid), 1);
      present(32'h00428333, 32'h404);
      #1;
      check_eq("fl_pre_ready", 32'(bus.id_ready), 0);
      bus.flush = 1'b1;
      #1;
      check_eq("fl_id_ready", 32'(bus.id_ready), 1);
      tick();
      check_eq("fl_ex_valid", 32'(bus.ex_valid), 0);
      bus.flush = 1'b0;
      present(32'h00428333, 32'h500);
      #1;
      check_eq("fl_next_ready", 32'(bus.id_ready), 1);
      tick();
      check_eq("fl_next_valid", 32'(bus.ex_valid), 1);
      check_eq("fl_next_pc", bus.ex_pc, 32'h500);

      // reset during a load-use stall
      present(32'h0080A283, 32'h600);
      tick();
      present(32'h00428333, 32'h604);
      rst = 1'b1;
      #1;
      check_eq("rs_id_ready", 32'(bus.id_ready), 0);
      tick();
      check_eq("rs_ex_valid", 32'(bus.ex_valid), 0);
      rst = 1'b0;
      #1;
      check_eq("rs_post_ready", 32'(bus.id_ready), 1);
      tick();
      check_eq("rs_post_valid", 32'(bus.ex_valid), 1);
      check_eq("rs_post_rd", 32'(bus.ex_rd), 6);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule

// File: doc/id_stage_pipe.md
Name: id_stage_pipe

Overview:
- Pipelined successor to the single-cycle decode stage for the RV32I core.
- Accepts an instruction/PC from IF over a valid/ready handshake.
- Decodes the instruction, reads the parametrised register file with write-back bypass, and detects load-use hazards.
- Registers all decoded fields into an ID/EX pipeline register with stall, bubble-insertion and flush control.

Parameters:
- XLEN, 32, register/data/PC width
- NUM_REG, 32, architectural registers; x0 hardwired zero
- REG_ADDR_WIDTH, $clog2(NUM_REG), register index width
- ALU_CONTROL_WIDTH, 4, ALU op encoding width
- RESULTSRC_WIDTH, 2, result mux select width

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- id_valid  in  1  IF/ID holds a valid instruction
- id_instr  in  32  instruction word
- id_pc  in  XLEN  PC of id_instr
- id_ready  out  1  ID consumes id_instr this cycle
- wb_we  in  1  write-back enable
- wb_rd  in  REG_ADDR_WIDTH  write-back destination
- wb_data  in  XLEN  write-back data
- flush  in  1  branch/jump redirect from EX; kill ID and ID/EX
- ex_ready  in  1  EX accepts ID/EX contents
- ex_valid  out  1  ID/EX holds a valid instruction
- ex_pc  out  XLEN  registered PC
- ex_rs1_data, ex_rs2_data  out  XLEN  registered operands
- ex_rs1, ex_rs2, ex_rd  out  REG_ADDR_WIDTH  registered indices
- ex_imm  out  XLEN  sign-extended immediate
- ex_alu_src, ex_mem_write, ex_reg_write, ex_branch, ex_jump  out  1  control bits
- ex_result_src  out  RESULTSRC_WIDTH  00 ALU, 01 mem, 10 PC+4
- ex_alu_control  out  ALU_CONTROL_WIDTH  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT, 6 SLL, 7 SRL, 8 SRA
- ex_illegal  out  1  unsupported opcode/funct

Behaviour:
- Clock and reset: one clock clk; reset rst is synchronous and active-high.
- Reset:
  - All ex_* outputs are 0; ex_valid=0.
  - All registers are cleared.
  - id_ready=0 during the reset cycle.
- Decoded opcodes:
  - R 0110011, I-ALU 0010011, load 0000011, store 0100011, branch 1100011 (BEQ/BNE), JAL 1101111, LUI 0110111.
  - Any other opcode: ex_illegal=1, ex_reg_write=0, ex_mem_write=0.
- ALU op selection:
  - R: funct7[5] selects SUB/SRA.
  - I-ALU: funct7[5] is honoured only for SRAI; ADDI never becomes SUB.
  - Branch: SUB.
- Immediates: I/S/B/J/U formats, sign-extended to XLEN. U format is instr[31:12]<<12.
- Register file:
  - NUM_REG x XLEN, written on clk when wb_we && wb_rd!=0.
  - Reads of x0 return 0.
  - Bypass: if wb_we && wb_rd!=0 && wb_rd==rs, the read returns wb_data in the same cycle.
- advance = !ex_valid || ex_ready.
- Load-use hazard:
  - hz = ex_valid && ex_result_src==01 && ex_rd!=0 && (ex_rd==rs1 && uses_rs1 || ex_rd==rs2 && uses_rs2).
  - uses_rs2 is true for R, store and branch only.
  - uses_rs1 is false for JAL and LUI.
- id_ready = !rst && (flush || advance && !hz).
- Next-state priority, one rule per cycle, evaluated in this order:
  1. rst: clear.
  2. flush: ex_valid<=0; current ID instruction is dropped (id_ready=1).
  3. !advance: hold ID/EX unchanged.
  4. hz: bubble (ex_valid<=0, ex_reg_write<=0, ex_mem_write<=0); ID holds.
  5. Otherwise: ex_valid<=id_valid, and all fields load from the decode.
- A bubble or id_valid=0 load forces ex_reg_write=ex_mem_write=ex_branch=ex_jump=0.
- Latency: one cycle from an accepted id_instr to ex_valid.
- Hazard is resolved after exactly one bubble, since the load advances to MEM.
- ex_rs*_data captured on a hold cycle stays stale; EX-side forwarding is outside this block.
- Reset mid-stall clears ex_valid and drops the hazard.

Test Plan:
- Write x2=5, x3=7 via wb port; id_instr=0x003100B3 (add x1,x2,x3) -> next cycle ex_valid=1, ex_rs1_data=5, ex_rs2_data=7, ex_rd=1, ex_alu_control=0, ex_reg_write=1.
- Same-cycle wb_we=1, wb_rd=2, wb_data=0xAA with id_instr reading x2 -> ex_rs1_data=0xAA; wb_rd=0 write -> x0 still reads 0.
- lw x5,8(x1) (0x0080A283) followed by add x6,x5,x4 -> one cycle with id_ready=0 and ex_valid=0 bubble, then the add issues with ex_rs1=5.
- ex_ready=0 for 3 cycles with a valid instruction in ID/EX -> ex_* stable, id_ready=0; release -> the next instruction loads.
- flush=1 during a load-use stall -> ex_valid=0 next cycle, id_ready=1, no bubble.
- Immediates: beq with offset -4 -> ex_imm=0xFFFFFFFC, ex_branch=1, ex_alu_control=1; addi x1,x0,-1 -> ex_imm=0xFFFFFFFF, ex_alu_control=0; opcode 0x7F -> ex_illegal=1, no writes enabled.
